xor_stream_decoder: RTL and testbench
=====================================

# xor_stream_decoder

Receive-side partner of the X/Y toggle-state encoder: it recovers the original X bit stream from the encoded state stream A and the companion Y stream. It inverts the encoder relation A(k) = A(k-1) ^ X(k) ^ Y(k). The recovered bits are deserialized LSB-first into W-bit words, and each word is presented on a valid/ready output port. The block sits at the link's receiving end, between the encoded serial input and the word-oriented consumer.

## Interface
- W, default 8: word width in bits (W >= 2).
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- SYNC  input  1  synchronous restart of decoding and deserialization.
- IN_VALID  input  1  A_IN/Y_IN carry one beat this cycle.
- A_IN  input  1  encoded state bit A(k) (encoder state after absorbing beat k).
- Y_IN  input  1  companion bit Y(k) of the same beat.
- X_OUT  output  1  last decoded bit (monitor).
- X_VALID  output  1  one-cycle pulse, X_OUT updated.
- OUT_DATA  output  W  assembled word, bit 0 = first received bit.
- OUT_VALID  output  1  OUT_DATA holds an unconsumed word.
- OUT_READY  input  1  consumer accepts word on an edge with OUT_VALID=1.
- OVERRUN  output  1  sticky flag: a completed word was dropped.
- ERR_CLR  input  1  synchronous clear of OVERRUN.

## Operation
- Registers:
  - prev_a: last accepted A, reset 0. This matches the encoder flip-flop reset.
  - shift: W bits.
  - bit_cnt: 0..W-1.
  - out_reg: W bits.
  - Output FSM with states S_EMPTY and S_FULL.
- Decode on every edge with IN_VALID=1 and SYNC=0:
  - x = A_IN ^ prev_a ^ Y_IN; prev_a <= A_IN.
  - shift[bit_cnt] <= x; X_OUT <= x; X_VALID <= 1.
  - If bit_cnt < W-1: bit_cnt increments.
  - If bit_cnt = W-1: the word is complete (shift with bit W-1 = x) and bit_cnt wraps to 0.
- IN_VALID=0: prev_a, shift and bit_cnt hold; X_VALID <= 0; X_OUT holds.
- Word completion while output free (S_EMPTY, or S_FULL with OUT_READY=1 on the same edge):
  - out_reg <= completed word; FSM goes to or stays in S_FULL.
- Word completion while S_FULL and OUT_READY=0:
  - The word is discarded and out_reg is unchanged.
  - OVERRUN <= 1.
  - Decoding continues (prev_a still updates, bit_cnt wraps to 0).
- Handshake: S_FULL with OUT_READY=1 and no completion → S_EMPTY.
- OUT_READY is ignored in S_EMPTY.
- SYNC=1 (priority over IN_VALID):
  - prev_a <= 0, bit_cnt <= 0, shift <= 0, X_VALID <= 0; the beat is not decoded.
  - out_reg, the FSM and the handshake are unaffected. A pending word remains and can still be accepted that edge.
- ERR_CLR=1 clears OVERRUN unless an overrun occurs on the same edge; set wins.
- OUT_VALID = (state == S_FULL); OUT_DATA = out_reg.

## Timing
- Reset (RST=0, asynchronous, immediate):
  - X_OUT=0, X_VALID=0, OUT_DATA=0, OUT_VALID=0, OVERRUN=0.
  - prev_a=0, bit_cnt=0, shift=0, FSM=S_EMPTY.
- Reset mid-word discards partial bits and any pending word. Release is sampled on the next rising edge.
- Bit latency: beat sampled at edge n → X_OUT/X_VALID valid after edge n, for one cycle.
- Word latency: the W-th beat sampled at edge n → OUT_VALID=1 and OUT_DATA valid after edge n.
- Throughput: one beat per cycle sustained. With OUT_READY held 1, back-to-back words lose nothing. A completion and an acceptance on the same edge replace the word with no bubble.
- OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
- Gaps in IN_VALID are transparent: the decode result depends only on the sequence of accepted beats.

## Test plan
- Basic decode, W=8, Y=0:
  - Stimulus: A beats 1,1,0,0,0,1,1,0, OUT_READY=1.
  - Response: X_OUT sequence 1,0,1,0,0,1,0,1; OUT_DATA=0xA5 with OUT_VALID=1 for one cycle after the 8th beat; OVERRUN=0.
- Y-only toggling, Y=1 every beat:
  - Stimulus: A beats 1,0,1,0,1,0,1,0.
  - Response: OUT_DATA=0x00. Then feed the encoder's output for X=0xFF, Y=1 (A constant 0) → OUT_DATA=0xFF.
- Backpressure/overrun:
  - Stimulus: OUT_READY=0; send encoded 0x3C, then encoded 0x96.
  - Response: OUT_DATA stays 0x3C; OVERRUN=1 after the 16th beat.
  - Then OUT_READY=1 for one cycle → OUT_VALID=0. ERR_CLR=1 → OVERRUN=0.
- SYNC mid-word:
  - Stimulus: 3 beats, then SYNC=1 with IN_VALID=1, then 8 beats encoding 0x5A from A reset 0.
  - Response: the SYNC beat is not decoded; OUT_DATA=0x5A; no word from the 3 partial beats.
- Async reset:
  - Stimulus: assert RST=0 between edges with OUT_VALID=1 and bit_cnt=5.
  - Response: all outputs 0 before the next edge. After release, the next 8 beats encoding 0xC3 → 0xC3.
- Gapped stream plus same-edge completion/accept:
  - Stimulus: encoded 0x11 then 0x22, IN_VALID toggling 1,0,1,0…; OUT_READY=1 exactly on the edge where 0x22 completes.
  - Response: 0x11 then 0x22, with no drop and no OVERRUN.

Source files
------------

// File: rtl/xor_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : xor_stream_decoder
//  Description : Receive-side partner of the X/Y toggle-state encoder.
//                Recovers X(k) = A(k) ^ A(k-1) ^ Y(k) from the encoded state
//                stream, deserializes the bits LSB-first into W-bit words and
//                presents each word on a valid/ready output port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W            word width in bits (W >= 2)
//  Ports
//    clk          sole clock, rising edge
//    rst_n        asynchronous active-low reset
//    i_sync       synchronous restart of decoding and deserialization
//    i_in_valid   i_a / i_y carry one beat this cycle
//    i_a          encoded state bit A(k)
//    i_y          companion bit Y(k)
//    o_x          last decoded bit (monitor)
//    o_x_valid    one-cycle pulse, o_x updated
//    o_out_data   assembled word, bit 0 = first received bit
//    o_out_valid  o_out_data holds an unconsumed word
//    i_out_ready  consumer accepts the word on an edge with o_out_valid = 1
//    o_overrun    sticky: a completed word was dropped
//    i_err_clr    synchronous clear of o_overrun (a same-edge overrun wins)
// ============================================================================
module xor_stream_decoder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_sync,
  input  logic         i_in_valid,
  input  logic         i_a,
  input  logic         i_y,
  output logic         o_x,
  output logic         o_x_valid,
  output logic [W-1:0] o_out_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_overrun,
  input  logic         i_err_clr
);

  localparam int             CNT_W    = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_prev_a;
  logic [CNT_W-1:0] r_bit_cnt;
  // Only the lower W-1 bits are stored: the final bit of a word is taken
  // straight from the decoder into the completed word on the same edge.
  logic [W-2:0]     r_shift;
  logic [W-1:0]     r_out;
  logic             r_x;
  logic             r_x_valid;
  logic             r_overrun;

  logic             w_x;
  logic             w_beat;
  logic             w_complete;
  logic             w_out_free;
  logic             w_drop;
  logic [W-1:0]     w_word;

  assign w_x        = i_a ^ r_prev_a ^ i_y;
  assign w_beat     = i_in_valid & ~i_sync;
  assign w_complete = w_beat & (r_bit_cnt == CNT_LAST);
  // The output slot can take a new word if it is empty or is being consumed
  // on this very edge (no bubble between back-to-back words).
  assign w_out_free = (r_state == S_EMPTY) | i_out_ready;
  assign w_drop     = w_complete & ~w_out_free;
  assign w_word     = {w_x, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_prev_a  <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_out     <= '0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // ---------------- decode / deserialize ----------------
      if (i_sync) begin
        r_prev_a  <= 1'b0;
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_x_valid <= 1'b0;
      end else if (i_in_valid) begin
        r_prev_a  <= i_a;
        r_x       <= w_x;
        r_x_valid <= 1'b1;
        for (int i = 0; i < W - 1; i++) begin
          if (r_bit_cnt == CNT_W'(i)) begin
            r_shift[i] <= w_x;
          end
        end
        if (r_bit_cnt == CNT_LAST) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end else begin
        r_x_valid <= 1'b0;
      end

      // ---------------- output slot FSM ----------------
      // Handshake is independent of i_sync: a pending word can still be
      // consumed while the decoder restarts.
      case (r_state)
        S_EMPTY: begin
          if (w_complete) begin
            r_out   <= w_word;
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_complete && i_out_ready) begin
            r_out   <= w_word;
            r_state <= S_FULL;
          end else if (i_out_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase

      // ---------------- sticky overrun ----------------
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_err_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_x         = r_x;
  assign o_x_valid   = r_x_valid;
  assign o_out_data  = r_out;
  assign o_out_valid = (r_state == S_FULL);
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_stream_decoder
//  Description : Self-checking bench for xor_stream_decoder. A behavioural
//                encoder (A = A ^ X ^ Y) produces the encoded stream from
//                chosen or random X words; decoded words are compared with
//                the original X words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_stream_decoder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_sync = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         i_a = 1'b0;
  logic         i_y = 1'b0;
  logic         i_out_ready = 1'b0;
  logic         i_err_clr = 1'b0;
  logic         o_x;
  logic         o_x_valid;
  logic [W-1:0] o_out_data;
  logic         o_out_valid;
  logic         o_overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic enc_a    = 1'b0;   // encoder model state

  xor_stream_decoder #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sync      (i_sync),
    .i_in_valid  (i_in_valid),
    .i_a         (i_a),
    .i_y         (i_y),
    .o_x         (o_x),
    .o_x_valid   (o_x_valid),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_overrun   (o_overrun),
    .i_err_clr   (i_err_clr)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Encode one X bit with companion Y and present it for one edge.
  task automatic send_bit(input logic x, input logic y);
    enc_a      = enc_a ^ x ^ y;
    i_in_valid = 1'b1;
    i_a        = enc_a;
    i_y        = y;
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i], 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (o_x !== 1'b0) begin n_fail++; $display("FAIL reset_x: got %b want 0", o_x); end
    n_checks++; if (o_x_valid !== 1'b0) begin n_fail++; $display("FAIL reset_x_valid: got %b want 0", o_x_valid); end
    n_checks++; if (o_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_out_data); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_out_valid); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    step(); step();
    rst_n = 1'b1;
    enc_a = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] a_seq;
    logic [7:0] x_exp;
    a_seq = 8'h63;   // beats 1,1,0,0,0,1,1,0 (bit 0 first)
    x_exp = 8'hA5;   // decoded 1,0,1,0,0,1,0,1
    i_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_in_valid = 1'b1; i_a = a_seq[i]; i_y = 1'b0;
      step();
      i_in_valid = 1'b0;
      n_checks++; if (o_x !== x_exp[i] || o_x_valid !== 1'b1) begin n_fail++; $display("FAIL basic_x[%0d]: got x=%b v=%b want x=%b v=1", i, o_x, o_x_valid, x_exp[i]); end
    end
    enc_a = 1'b0;
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'hA5) begin n_fail++; $display("FAIL basic_word: got v=%b d=%h want v=1 d=a5", o_out_valid, o_out_data); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", o_overrun); end
    step();
    n_checks++; if (o_out_valid !== 1'b0 || o_x_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got v=%b xv=%b want 0 0", o_out_valid, o_x_valid); end
  endtask

  task automatic test_y_only();
    logic [7:0] a_seq;
    a_seq = 8'h55;   // beats 1,0,1,0,...
    for (int i = 0; i < 8; i++) begin
      i_in_valid = 1'b1; i_a = a_seq[i]; i_y = 1'b1;
      step();
    end
    i_in_valid = 1'b0;
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h00) begin n_fail++; $display("FAIL yonly_zero: got v=%b d=%h want v=1 d=00", o_out_valid, o_out_data); end
    enc_a = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);   // A stays 0
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'hFF) begin n_fail++; $display("FAIL yonly_ff: got v=%b d=%h want v=1 d=ff", o_out_valid, o_out_data); end
    step();
  endtask

  task automatic test_backpressure();
    i_out_ready = 1'b0;
    send_word(8'h3C);
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h3C || o_overrun !== 1'b0) begin n_fail++; $display("FAIL bp_first: got v=%b d=%h ovr=%b want 1 3c 0", o_out_valid, o_out_data, o_overrun); end
    send_word(8'h96);
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=3c", o_out_valid, o_out_data); end
    n_checks++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b want 1", o_overrun); end
    i_out_ready = 1'b1; step(); i_out_ready = 1'b0;
    n_checks++; if (o_out_valid !== 1'b0 || o_overrun !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got v=%b ovr=%b want 0 1", o_out_valid, o_overrun); end
    i_err_clr = 1'b1; step(); i_err_clr = 1'b0;
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL bp_errclr: got %b want 0", o_overrun); end
  endtask

  task automatic test_sync();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    i_sync = 1'b1; i_in_valid = 1'b1; i_a = 1'b1; i_y = 1'b0;
    step();
    i_sync = 1'b0; i_in_valid = 1'b0;
    enc_a = 1'b0;
    n_checks++; if (o_x_valid !== 1'b0 || o_out_valid !== 1'b0) begin n_fail++; $display("FAIL sync_beat: got xv=%b v=%b want 0 0", o_x_valid, o_out_valid); end
    send_word(8'h5A);
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h5A) begin n_fail++; $display("FAIL sync_word: got v=%b d=%h want v=1 d=5a", o_out_valid, o_out_data); end
    i_out_ready = 1'b1; step(); i_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] w1;
    w1 = 8'($urandom);
    send_word(w1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== w1) begin n_fail++; $display("FAIL arst_pre: got v=%b d=%h want v=1 d=%h", o_out_valid, o_out_data, w1); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({o_x, o_x_valid, o_out_valid, o_overrun} !== 4'b0000 || o_out_data !== 8'h00) begin n_fail++; $display("FAIL arst_outputs: got x=%b xv=%b v=%b ovr=%b d=%h want all 0", o_x, o_x_valid, o_out_valid, o_overrun, o_out_data); end
    step();
    rst_n = 1'b1;
    enc_a = 1'b0;
    step();
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_release: got v=%b want 0", o_out_valid); end
    i_out_ready = 1'b1;
    send_word(8'hC3);
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'hC3) begin n_fail++; $display("FAIL arst_word: got v=%b d=%h want v=1 d=c3", o_out_valid, o_out_data); end
    step();
    i_out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    i_out_ready = 1'b0;
    w = 8'h11;
    for (int i = 0; i < 8; i++) begin send_bit(w[i], 1'($urandom_range(0, 1))); step(); end
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h11) begin n_fail++; $display("FAIL gap_first: got v=%b d=%h want v=1 d=11", o_out_valid, o_out_data); end
    w = 8'h22;
    for (int i = 0; i < 7; i++) begin send_bit(w[i], 1'($urandom_range(0, 1))); step(); end
    n_checks++; if (o_out_data !== 8'h11) begin n_fail++; $display("FAIL gap_hold: got d=%h want d=11", o_out_data); end
    i_out_ready = 1'b1;
    send_bit(w[7], 1'($urandom_range(0, 1)));
    i_out_ready = 1'b0;
    n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h22 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL gap_replace: got v=%b d=%h ovr=%b want 1 22 0", o_out_valid, o_out_data, o_overrun); end
    i_out_ready = 1'b1; step();
  endtask

  task automatic test_random();
    logic [7:0] w;
    i_out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      w = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        send_bit(w[i], 1'($urandom_range(0, 1)));
        n_checks++; if (o_x !== w[i] || o_x_valid !== 1'b1) begin n_fail++; $display("FAIL rand_x w%0d b%0d: got x=%b v=%b want x=%b v=1", n, i, o_x, o_x_valid, w[i]); end
        if (i != 7 && $urandom_range(0, 3) == 0) step();
      end
      n_checks++; if (o_out_valid !== 1'b1 || o_out_data !== w) begin n_fail++; $display("FAIL rand_word %0d: got v=%b d=%h want v=1 d=%h", n, o_out_valid, o_out_data, w); end
    end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL rand_overrun: got %b want 0", o_overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_y_only();
    test_backpressure();
    test_sync();
    test_async_reset();
    test_gapped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
